// File: rtl/pipeline_mem_pkg.sv
// Shared definitions for the MEM stage: size codes, result-select bits, FSM states,
// the EX/MEM pipeline register layout and the alignment check.
package pipeline_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] SRC_ALU = 4'b0001;
   localparam logic [3:0] SRC_IMM = 4'b0010;
   localparam logic [3:0] SRC_MEM = 4'b0100;
   localparam logic [3:0] SRC_PC4 = 4'b1000;

   typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRvalid, StDone} mem_state_e;

   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] store_data;
      logic [31:0] ext_imm;
      logic [31:0] pc_plus4;
      logic [31:0] pc_instr;
      logic        reg_write_en;
      logic [4:0]  rd_idx;
      logic [3:0]  result_src;
      logic        mem_read;
      logic        mem_write;
      logic [2:0]  funct3;
   } ex_mem_t;

   function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3[1:0])
         2'b01:   return addr_lo[0];
         2'b10:   return addr_lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pipeline_mem_if.sv
// Data-memory req/gnt/rvalid bus between the MEM stage (master) and memory (slave).
interface pipeline_mem_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/pipeline_mem_align_unit.sv
// Combinational byte-lane logic: store byte enables / lane-replicated write data,
// load lane extraction with sign or zero extension.
module pipeline_mem_align_unit
   import pipeline_mem_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_data_o
);

   logic [31:0] lane;

   always_comb begin
      lane        = rdata_i >> {addr_lo_i, 3'b000};
      be_o        = 4'b1111;
      wdata_o     = store_data_i;
      load_data_o = lane;

      case (funct3_i)
         F3_B, F3_BU: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{store_data_i[7:0]}};
         end
         F3_H, F3_HU: begin
            be_o    = 4'b0011 << addr_lo_i;
            wdata_o = {2{store_data_i[15:0]}};
         end
         default: ;
      endcase

      case (funct3_i)
         F3_B:    load_data_o = {{24{lane[7]}}, lane[7:0]};
         F3_H:    load_data_o = {{16{lane[15]}}, lane[15:0]};
         F3_BU:   load_data_o = {24'b0, lane[7:0]};
         F3_HU:   load_data_o = {16'b0, lane[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/pipeline_mem.sv
// MEM stage: EX/MEM register, data-memory access FSM with timeout, WB-facing outputs.
module pipeline_mem
   import pipeline_mem_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h8000_0000,
   parameter int unsigned BUS_TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          valid_e_i,
   input  logic          flush_m_i,
   input  logic [31:0]   alu_result_e_i,
   input  logic [31:0]   store_data_e_i,
   input  logic [31:0]   extended_imm_e_i,
   input  logic [31:0]   pc_plus4_e_i,
   input  logic [31:0]   pc_instr_e_i,
   input  logic          reg_write_en_e_i,
   input  logic [4:0]    rd_idx_e_i,
   input  logic [3:0]    result_src_e_i,
   input  logic          mem_read_e_i,
   input  logic          mem_write_e_i,
   input  logic [2:0]    funct3_e_i,
   output logic          stall_m_o,
   pipeline_mem_if.master dmem,
   output logic [31:0]   alu_result_m_o,
   output logic [31:0]   extended_imm_m_o,
   output logic [31:0]   pc_plus4_m_o,
   output logic [31:0]   mem_read_data_m_o,
   output logic          reg_write_en_m_o,
   output logic [4:0]    rd_idx_m_o,
   output logic [3:0]    result_src_m_o,
   output logic [31:0]   pc_instr_m_o,
   output logic          misalign_m_o,
   output logic          bus_err_m_o
);

   localparam int unsigned CntW = $clog2(BUS_TIMEOUT + 1);

   ex_mem_t         ex_d, ex_q;
   mem_state_e      state_q;
   logic [CntW-1:0] cnt_q;
   logic [31:0]     rdata_q;
   logic            bubble, is_mem, misaligned, in_wait, timeout, req, finish;
   logic [3:0]      be;
   logic [31:0]     wdata, load_data;

   assign bubble = flush_m_i | ~valid_e_i;

   always_comb begin
      ex_d              = '0;
      ex_d.alu_result   = alu_result_e_i;
      ex_d.store_data   = store_data_e_i;
      ex_d.ext_imm      = extended_imm_e_i;
      ex_d.pc_plus4     = pc_plus4_e_i;
      ex_d.pc_instr     = pc_instr_e_i;
      ex_d.reg_write_en = reg_write_en_e_i & ~bubble;
      ex_d.rd_idx       = rd_idx_e_i;
      ex_d.result_src   = result_src_e_i;
      ex_d.mem_read     = mem_read_e_i & ~bubble;
      ex_d.mem_write    = mem_write_e_i & ~bubble;
      ex_d.funct3       = funct3_e_i;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ex_q          <= '0;
         ex_q.pc_instr <= RESET_PC;
      end else if (!stall_m_o) begin
         ex_q <= ex_d;
      end
   end

   assign is_mem     = ex_q.mem_read | ex_q.mem_write;
   assign misaligned = is_mem & addr_misaligned(ex_q.funct3, ex_q.alu_result[1:0]);
   assign in_wait    = (state_q == StWaitGnt) | (state_q == StWaitRvalid);
   // Timeout fires on the BUS_TIMEOUT-th cycle spent in a wait state.
   assign timeout    = in_wait & (cnt_q == CntW'(BUS_TIMEOUT - 1));
   // resetn gates req so an access is abandoned in the cycle reset is sampled.
   assign req        = resetn & is_mem & ~misaligned &
                       ((state_q == StIdle) | ((state_q == StWaitGnt) & ~timeout));

   always_comb begin
      finish = 1'b0;
      case (state_q)
         StIdle:       finish = misaligned | (ex_q.mem_write & req & dmem.gnt);
         StWaitGnt:    finish = timeout | (ex_q.mem_write & dmem.gnt);
         StWaitRvalid: finish = timeout;
         StDone:       finish = 1'b1;
      endcase
   end

   assign stall_m_o = is_mem & ~finish;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req) begin
                  cnt_q <= '0;
                  if (!dmem.gnt)          state_q <= StWaitGnt;
                  else if (ex_q.mem_read) state_q <= StWaitRvalid;
               end
            end
            StWaitGnt: begin
               if (timeout) begin
                  state_q <= StIdle;
               end else if (dmem.gnt) begin
                  cnt_q   <= '0;
                  state_q <= ex_q.mem_read ? StWaitRvalid : StIdle;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StWaitRvalid: begin
               if (timeout) begin
                  state_q <= StIdle;
               end else if (dmem.rvalid) begin
                  rdata_q <= load_data;
                  state_q <= StDone;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StDone: state_q <= StIdle;
         endcase
      end
   end

   pipeline_mem_align_unit u_align (
      .funct3_i     (ex_q.funct3),
      .addr_lo_i    (ex_q.alu_result[1:0]),
      .store_data_i (ex_q.store_data),
      .rdata_i      (dmem.rdata),
      .be_o         (be),
      .wdata_o      (wdata),
      .load_data_o  (load_data)
   );

   assign dmem.req   = req;
   assign dmem.we    = req & ex_q.mem_write;
   assign dmem.addr  = req ? {ex_q.alu_result[31:2], 2'b00} : 32'b0;
   assign dmem.be    = req ? be : 4'b0;
   assign dmem.wdata = (req & ex_q.mem_write) ? wdata : 32'b0;

   assign alu_result_m_o    = ex_q.alu_result;
   assign extended_imm_m_o  = ex_q.ext_imm;
   assign pc_plus4_m_o      = ex_q.pc_plus4;
   assign pc_instr_m_o      = ex_q.pc_instr;
   assign rd_idx_m_o        = ex_q.rd_idx;
   assign result_src_m_o    = ex_q.result_src;
   assign mem_read_data_m_o = rdata_q;
   assign reg_write_en_m_o  = ex_q.reg_write_en & (~is_mem | (state_q == StDone));
   assign misalign_m_o      = misaligned;
   assign bus_err_m_o       = timeout;

endmodule

// File: tb/tb_pipeline_mem.sv
// Directed bench for pipeline_mem: ALU pass-through, stores, loads, misalignment,
// delayed grant, bus timeout and reset during an outstanding load.
module tb_pipeline_mem;
   import pipeline_mem_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn, valid_e, flush_m;
   logic [31:0] alu_result_e, store_data_e, extended_imm_e, pc_plus4_e, pc_instr_e;
   logic        reg_write_en_e, mem_read_e, mem_write_e;
   logic [4:0]  rd_idx_e;
   logic [3:0]  result_src_e;
   logic [2:0]  funct3_e;
   logic        stall_m, reg_write_en_m, misalign_m, bus_err_m;
   logic [31:0] alu_result_m, extended_imm_m, pc_plus4_m, mem_read_data_m, pc_instr_m;
   logic [4:0]  rd_idx_m;
   logic [3:0]  result_src_m;

   pipeline_mem_if dmem ();

   pipeline_mem dut (
      .clk               (clk),
      .resetn            (resetn),
      .valid_e_i         (valid_e),
      .flush_m_i         (flush_m),
      .alu_result_e_i    (alu_result_e),
      .store_data_e_i    (store_data_e),
      .extended_imm_e_i  (extended_imm_e),
      .pc_plus4_e_i      (pc_plus4_e),
      .pc_instr_e_i      (pc_instr_e),
      .reg_write_en_e_i  (reg_write_en_e),
      .rd_idx_e_i        (rd_idx_e),
      .result_src_e_i    (result_src_e),
      .mem_read_e_i      (mem_read_e),
      .mem_write_e_i     (mem_write_e),
      .funct3_e_i        (funct3_e),
      .stall_m_o         (stall_m),
      .dmem              (dmem),
      .alu_result_m_o    (alu_result_m),
      .extended_imm_m_o  (extended_imm_m),
      .pc_plus4_m_o      (pc_plus4_m),
      .mem_read_data_m_o (mem_read_data_m),
      .reg_write_en_m_o  (reg_write_en_m),
      .rd_idx_m_o        (rd_idx_m),
      .result_src_m_o    (result_src_m),
      .pc_instr_m_o      (pc_instr_m),
      .misalign_m_o      (misalign_m),
      .bus_err_m_o       (bus_err_m)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic [31:0] alu, input logic [31:0] sdata, input logic [2:0] f3,
                         input logic mr, input logic mw, input logic rwe, input logic [4:0] rd,
                         input logic [3:0] src, input logic [31:0] pc);
      valid_e        = 1'b1;
      flush_m        = 1'b0;
      alu_result_e   = alu;
      store_data_e   = sdata;
      funct3_e       = f3;
      mem_read_e     = mr;
      mem_write_e    = mw;
      reg_write_en_e = rwe;
      rd_idx_e       = rd;
      result_src_e   = src;
      pc_instr_e     = pc;
      pc_plus4_e     = pc + 32'd4;
      extended_imm_e = 32'h0000_5000;
   endtask

   task automatic clear_ex();
      valid_e        = 1'b0;
      flush_m        = 1'b0;
      mem_read_e     = 1'b0;
      mem_write_e    = 1'b0;
      reg_write_en_e = 1'b0;
   endtask

   // Store with grant in the first MEM cycle.
   task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] data, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      set_ex(addr, data, f3, 1'b0, 1'b1, 1'b0, 5'd0, SRC_ALU, 32'h0000_2000);
      step();
      clear_ex();
      dmem.gnt = 1'b1;
      #1;
      check({tag, " req"}, 32'(dmem.req), 32'd1);
      check({tag, " we"}, 32'(dmem.we), 32'd1);
      check({tag, " addr"}, dmem.addr, exp_addr);
      check({tag, " be"}, 32'(dmem.be), 32'(exp_be));
      check({tag, " wdata"}, dmem.wdata, exp_wdata);
      check({tag, " stall"}, 32'(stall_m), 32'd0);
      step();
      dmem.gnt = 1'b0;
      #1;
      check({tag, " req after"}, 32'(dmem.req), 32'd0);
   endtask

   // Load with grant immediately and rvalid one cycle later: three MEM cycles.
   task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rdata, input logic [31:0] exp_data);
      set_ex(addr, 32'h0, f3, 1'b1, 1'b0, 1'b1, 5'd7, SRC_MEM, 32'h0000_3000);
      step();
      clear_ex();
      dmem.gnt = 1'b1;
      #1;
      check({tag, " c1 req"}, 32'(dmem.req), 32'd1);
      check({tag, " c1 addr"}, dmem.addr, 32'h0000_0100);
      check({tag, " c1 stall"}, 32'(stall_m), 32'd1);
      check({tag, " c1 rwe"}, 32'(reg_write_en_m), 32'd0);
      step();
      dmem.gnt    = 1'b0;
      dmem.rvalid = 1'b1;
      dmem.rdata  = rdata;
      #1;
      check({tag, " c2 req"}, 32'(dmem.req), 32'd0);
      check({tag, " c2 stall"}, 32'(stall_m), 32'd1);
      step();
      dmem.rvalid = 1'b0;
      dmem.rdata  = 32'h0;
      #1;
      check({tag, " c3 stall"}, 32'(stall_m), 32'd0);
      check({tag, " c3 rwe"}, 32'(reg_write_en_m), 32'd1);
      check({tag, " c3 data"}, mem_read_data_m, exp_data);
      check({tag, " c3 rd"}, 32'(rd_idx_m), 32'd7);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int err_at;
      int req_cycles;

      resetn      = 1'b0;
      dmem.gnt    = 1'b0;
      dmem.rvalid = 1'b0;
      dmem.rdata  = 32'h0;
      set_ex(32'h0, 32'h0, F3_W, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0, 32'h0);
      clear_ex();
      step();
      step();
      #1;
      check("reset pc", pc_instr_m, 32'h8000_0000);
      check("reset alu", alu_result_m, 32'h0);
      check("reset rwe", 32'(reg_write_en_m), 32'd0);
      check("reset req", 32'(dmem.req), 32'd0);
      check("reset stall", 32'(stall_m), 32'd0);
      check("reset rdata", mem_read_data_m, 32'h0);
      check("reset src", 32'(result_src_m), 32'd0);
      resetn = 1'b1;
      step();

      // ALU op passes straight through in one cycle.
      set_ex(32'h0000_1234, 32'h0, F3_W, 1'b0, 1'b0, 1'b1, 5'd5, SRC_ALU, 32'h0000_1000);
      step();
      clear_ex();
      dmem.gnt = 1'b1;  // gnt with nothing requested is ignored
      #1;
      check("alu result", alu_result_m, 32'h0000_1234);
      check("alu rwe", 32'(reg_write_en_m), 32'd1);
      check("alu stall", 32'(stall_m), 32'd0);
      check("alu rd", 32'(rd_idx_m), 32'd5);
      check("alu pc", pc_instr_m, 32'h0000_1000);
      check("alu pc4", pc_plus4_m, 32'h0000_1004);
      check("alu imm", extended_imm_m, 32'h0000_5000);
      check("alu req", 32'(dmem.req), 32'd0);
      step();
      dmem.gnt = 1'b0;

      // Flushed instruction becomes a bubble.
      set_ex(32'h0000_0055, 32'h0, F3_W, 1'b0, 1'b0, 1'b1, 5'd6, SRC_ALU, 32'h0000_1100);
      flush_m = 1'b1;
      step();
      clear_ex();
      #1;
      check("flush rwe", 32'(reg_write_en_m), 32'd0);
      step();

      do_store("sw", 32'h0000_0100, F3_W, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
      do_store("sh", 32'h0000_0102, F3_H, 32'h0000_ABCD, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD);
      do_store("sb", 32'h0000_0101, F3_B, 32'h1234_5678, 32'h0000_0100, 4'b0010, 32'h7878_7878);

      do_load("lb", 32'h0000_0103, F3_B, 32'h80FF_FF7F, 32'hFFFF_FF80);
      do_load("lbu", 32'h0000_0103, F3_BU, 32'h80FF_FF7F, 32'h0000_0080);
      do_load("lh", 32'h0000_0100, F3_H, 32'h80FF_FF7F, 32'hFFFF_FF7F);
      do_load("lhu", 32'h0000_0102, F3_HU, 32'h80FF_FF7F, 32'h0000_80FF);
      do_load("lw", 32'h0000_0100, F3_W, 32'h80FF_FF7F, 32'h80FF_FF7F);

      // Misaligned word load: pulse, no request, no stall, no write.
      set_ex(32'h0000_0102, 32'h0, F3_W, 1'b1, 1'b0, 1'b1, 5'd8, SRC_MEM, 32'h0000_4000);
      step();
      clear_ex();
      #1;
      check("mis pulse", 32'(misalign_m), 32'd1);
      check("mis req", 32'(dmem.req), 32'd0);
      check("mis stall", 32'(stall_m), 32'd0);
      check("mis rwe", 32'(reg_write_en_m), 32'd0);
      step();
      #1;
      check("mis pulse end", 32'(misalign_m), 32'd0);

      // Grant withheld for 3 cycles; a flush while stalled must not disturb the access.
      set_ex(32'h0000_0200, 32'h0000_55AA, F3_W, 1'b0, 1'b1, 1'b0, 5'd0, SRC_ALU, 32'h0000_5000);
      step();
      clear_ex();
      flush_m = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dmem.gnt = (i == 3);
         #1;
         check($sformatf("hold%0d req", i), 32'(dmem.req), 32'd1);
         check($sformatf("hold%0d addr", i), dmem.addr, 32'h0000_0200);
         check($sformatf("hold%0d wdata", i), dmem.wdata, 32'h0000_55AA);
         check($sformatf("hold%0d stall", i), 32'(stall_m), (i < 3) ? 32'd1 : 32'd0);
         step();
      end
      dmem.gnt = 1'b0;
      flush_m  = 1'b0;
      #1;
      check("hold req after", 32'(dmem.req), 32'd0);

      // No grant at all: bus error on the 256th MEM cycle (1 idle + 255 waiting).
      set_ex(32'h0000_0300, 32'h0, F3_W, 1'b1, 1'b0, 1'b1, 5'd3, SRC_MEM, 32'h0000_6000);
      step();
      clear_ex();
      err_at     = -1;
      req_cycles = 0;
      for (int i = 0; i < 400; i++) begin
         #1;
         if (bus_err_m) begin
            err_at = i;
            check("tmo req", 32'(dmem.req), 32'd0);
            check("tmo stall", 32'(stall_m), 32'd0);
            check("tmo rwe", 32'(reg_write_en_m), 32'd0);
            break;
         end
         if (dmem.req) req_cycles++;
         step();
      end
      check("tmo cycle", 32'(err_at), 32'd255);
      check("tmo req cycles", 32'(req_cycles), 32'd255);
      step();
      #1;
      check("tmo pulse end", 32'(bus_err_m), 32'd0);
      check("tmo idle req", 32'(dmem.req), 32'd0);

      // Reset during WAIT_RVALID; the late rvalid must be ignored.
      set_ex(32'h0000_0400, 32'h0, F3_W, 1'b1, 1'b0, 1'b1, 5'd9, SRC_MEM, 32'h0000_7000);
      step();
      clear_ex();
      dmem.gnt = 1'b1;
      #1;
      check("rst lw req", 32'(dmem.req), 32'd1);
      step();
      dmem.gnt = 1'b0;
      #1;
      check("rst wait stall", 32'(stall_m), 32'd1);
      resetn = 1'b0;
      #1;
      check("rst req low", 32'(dmem.req), 32'd0);
      step();
      resetn = 1'b1;
      #1;
      check("rst pc", pc_instr_m, 32'h8000_0000);
      check("rst stall", 32'(stall_m), 32'd0);
      check("rst req", 32'(dmem.req), 32'd0);
      dmem.rvalid = 1'b1;
      dmem.rdata  = 32'hCAFE_F00D;
      step();
      dmem.rvalid = 1'b0;
      #1;
      check("rst late rdata", mem_read_data_m, 32'h0);
      check("rst late rwe", 32'(reg_write_en_m), 32'd0);
      check("rst late stall", 32'(stall_m), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
